muntjac_csr_responder: RTL and testbench
========================================

// Module: muntjac_csr_responder
// PURPOSE
//  Responder end of the CSR access interface: accepts csr_op_e requests from the
//  core's CSR initiator, checks privilege/read-only rules against priv_lvl_e, applies
//  READ/WRITE/SET/CLEAR to a small machine/supervisor CSR set, returns old value or error.
//  Sits beside the execute stage; valid/ready request and response channels, 1-cycle latency.
// PARAMETERS
//  XLEN     64       data width of CSRs and request/response data
//  HartId   0        value returned by mhartid (zero-extended to XLEN)
// PORTS
//  clk_i         in   1     clock
//  rst_ni        in   1     asynchronous reset, active low
//  req_valid_i   in   1     request valid
//  req_ready_o   out  1     request ready
//  req_op_i      in   2     csr_op_e: READ/WRITE/SET/CLEAR
//  req_addr_i    in   12    CSR address
//  req_wdata_i   in   XLEN  write/set/clear operand
//  req_priv_i    in   2     priv_lvl_e of the requesting instruction
//  resp_valid_o  out  1     response valid
//  resp_ready_i  in   1     response ready
//  resp_rdata_o  out  XLEN  CSR value before the access (0 on error)
//  resp_error_o  out  1     illegal access (raise illegal-instruction)
// BEHAVIOUR
//  - Clock clk_i; reset rst_ni asynchronous, active low. Reset: resp_valid_o=0,
//    resp_rdata_o=0, resp_error_o=0, mscratch=sscratch=mcycle=0.
//  - CSR map: 0x340 mscratch RW; 0x140 sscratch RW; 0xB00 mcycle RW;
//    0xC00 cycle RO alias of mcycle; 0xF14 mhartid RO = HartId. Others: unmapped.
//  - Handshake: accept = req_valid_i & req_ready_o; req_ready_o = !resp_valid_o | resp_ready_i
//    (combinational from resp_ready_i; back-to-back accept allowed).
//  - Response registered on the cycle after accept; held stable while resp_valid_o & !resp_ready_i.
//    resp_valid_o clears after handshake unless a new request is accepted same cycle.
//  - write_intent = (op==WRITE) | ((op==SET|op==CLEAR) & wdata!=0). READ never writes.
//  - error = unmapped addr | (req_priv_i < addr[9:8], unsigned compare)
//            | (addr[11:10]==2'b11 & write_intent).
//  - new value: WRITE wdata; SET old|wdata; CLEAR old&~wdata. Written at accept edge
//    only if write_intent & !error. On error: no state change, rdata=0, error=1.
//  - rdata = value at accept cycle (before that cycle's write/increment).
//  - mcycle increments by 1 every cycle, wraps 2^XLEN-1 -> 0. Software write to mcycle
//    in accept cycle wins over increment; next cycle increments from written value.
//  - cycle (0xC00) readable from any priv (addr[9:8]=0); writes error (read-only).
//  - Reset mid-transaction: pending response dropped, resp_valid_o=0 immediately.
// TESTING
//  1 Reset: rst_ni low mid-response -> resp_valid_o=0, mscratch reads 0 after release.
//  2 M WRITE 0x340 wdata=0xDEAD -> rdata=0, err=0; M READ 0x340 -> rdata=0xDEAD.
//  3 mscratch=0xF0; SET 0x0F -> rdata=0xF0, then =0xFF; CLEAR 0xF0 -> rdata=0xFF, then =0x0F.
//  4 U READ 0x340 -> err=1, rdata=0; S WRITE 0x140 0x5 ok; U SET 0xC00 wdata=0 -> ok, rdata=mcycle
//    value; U WRITE 0xC00 -> err=1; M READ 0xF14 -> HartId; READ 0x7FF -> err=1.
//  5 mcycle: M WRITE 0xB00 =2^XLEN-1, idle, READ -> 2^XLEN-1+n wrapped (0 after 1 cycle).
//  6 Backpressure: resp_ready_i=0 for 3 cycles with req_valid_i=1 -> req_ready_o=0, response
//    stable; release -> response and next request accepted same cycle, 1 response/cycle after.

Source files
------------

// File: rtl/muntjac_csr_responder.sv
// CSR responder: privilege/read-only checked READ/WRITE/SET/CLEAR access to a small
// machine/supervisor CSR set, answering on a registered valid/ready response channel.
module muntjac_csr_responder #(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned HartId = 0
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [1:0]      req_op_i,
  input  logic [11:0]     req_addr_i,
  input  logic [XLEN-1:0] req_wdata_i,
  input  logic [1:0]      req_priv_i,
  output logic            resp_valid_o,
  input  logic            resp_ready_i,
  output logic [XLEN-1:0] resp_rdata_o,
  output logic            resp_error_o
);

  localparam logic [1:0]  OP_READ  = 2'd0;
  localparam logic [1:0]  OP_WRITE = 2'd1;
  localparam logic [1:0]  OP_SET   = 2'd2;
  localparam logic [1:0]  OP_CLEAR = 2'd3;

  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_SSCRATCH = 12'h140;
  localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
  localparam logic [11:0] ADDR_CYCLE    = 12'hC00;
  localparam logic [11:0] ADDR_MHARTID  = 12'hF14;

  logic [XLEN-1:0] r_mscratch;
  logic [XLEN-1:0] r_sscratch;
  logic [XLEN-1:0] r_mcycle;
  logic            r_resp_valid;
  logic [XLEN-1:0] r_resp_rdata;
  logic            r_resp_error;

  logic            w_accept;
  logic            w_mapped;
  logic [XLEN-1:0] w_old;
  logic [XLEN-1:0] w_new;
  logic            w_write_intent;
  logic            w_error;
  logic            w_do_write;

  assign req_ready_o  = !r_resp_valid || resp_ready_i;
  assign w_accept     = req_valid_i && req_ready_o;
  assign resp_valid_o = r_resp_valid;
  assign resp_rdata_o = r_resp_rdata;
  assign resp_error_o = r_resp_error;

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    w_mapped = 1'b0;
    w_old    = '0;
    case (req_addr_i)
      ADDR_MSCRATCH: begin w_mapped = 1'b1; w_old = r_mscratch; end
      ADDR_SSCRATCH: begin w_mapped = 1'b1; w_old = r_sscratch; end
      ADDR_MCYCLE:   begin w_mapped = 1'b1; w_old = r_mcycle;   end
      ADDR_CYCLE:    begin w_mapped = 1'b1; w_old = r_mcycle;   end
      ADDR_MHARTID:  begin w_mapped = 1'b1; w_old = XLEN'(HartId); end
      default:       begin w_mapped = 1'b0; w_old = '0;          end
    endcase
  end

  always_comb begin
    w_new = w_old;
    case (req_op_i)
      OP_READ:  w_new = w_old;
      OP_WRITE: w_new = req_wdata_i;
      OP_SET:   w_new = w_old | req_wdata_i;
      OP_CLEAR: w_new = w_old & ~req_wdata_i;
      default:  w_new = w_old;
    endcase
  end

  // SET/CLEAR with a zero operand is a pure read, so it may target read-only CSRs.
  assign w_write_intent = (req_op_i == OP_WRITE) ||
                          (((req_op_i == OP_SET) || (req_op_i == OP_CLEAR)) && (|req_wdata_i));
  assign w_error        = !w_mapped || (req_priv_i < req_addr_i[9:8]) ||
                          ((req_addr_i[11:10] == 2'b11) && w_write_intent);
  assign w_do_write     = w_accept && w_write_intent && !w_error;

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_error <= 1'b0;
    end else if (w_accept) begin
      r_resp_valid <= 1'b1;
      r_resp_rdata <= w_error ? '0 : w_old;
      r_resp_error <= w_error;
    end else if (resp_ready_i) begin
      r_resp_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_mscratch <= '0;
      r_sscratch <= '0;
    end else if (w_do_write) begin
      if (req_addr_i == ADDR_MSCRATCH) r_mscratch <= w_new;
      if (req_addr_i == ADDR_SSCRATCH) r_sscratch <= w_new;
    end
  end

  // A software write in the accept cycle replaces that cycle's increment.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_mcycle <= '0;
    end else if (w_do_write && (req_addr_i == ADDR_MCYCLE)) begin
      r_mcycle <= w_new;
    end else begin
      r_mcycle <= r_mcycle + XLEN'(1);
    end
  end

endmodule

// File: tb/tb_muntjac_csr_responder.sv
// Directed bench for muntjac_csr_responder: table of single accesses plus hand-written
// reset, mcycle-wrap and backpressure sequences.
module tb_muntjac_csr_responder;

  localparam logic [1:0] OP_READ  = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_SET   = 2'd2;
  localparam logic [1:0] OP_CLEAR = 2'd3;
  localparam logic [1:0] PRIV_U   = 2'd0;
  localparam logic [1:0] PRIV_S   = 2'd1;
  localparam logic [1:0] PRIV_M   = 2'd3;
  localparam logic [63:0] ALL_ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [1:0]  req_op_i;
  logic [11:0] req_addr_i;
  logic [63:0] req_wdata_i;
  logic [1:0]  req_priv_i;
  logic        resp_valid_o;
  logic        resp_ready_i;
  logic [63:0] resp_rdata_o;
  logic        resp_error_o;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [1:0]  op;
    logic [11:0] addr;
    logic [63:0] wdata;
    logic [1:0]  priv;
    logic [63:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  muntjac_csr_responder #(.XLEN(64), .HartId(5)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_op_i    (req_op_i),
    .req_addr_i  (req_addr_i),
    .req_wdata_i (req_wdata_i),
    .req_priv_i  (req_priv_i),
    .resp_valid_o(resp_valid_o),
    .resp_ready_i(resp_ready_i),
    .resp_rdata_o(resp_rdata_o),
    .resp_error_o(resp_error_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [1:0] op, input logic [11:0] addr, input logic [63:0] wd,
                         input logic [1:0] priv, input logic [63:0] rd, input logic err);
    vec_t v;
    v.op = op; v.addr = addr; v.wdata = wd; v.priv = priv; v.exp_rdata = rd; v.exp_err = err;
    vecs.push_back(v);
  endtask

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic do_req(input logic [1:0] op, input logic [11:0] addr, input logic [63:0] wd,
                        input logic [1:0] priv, output logic [63:0] rd, output logic er);
    req_valid_i = 1'b1;
    req_op_i    = op;
    req_addr_i  = addr;
    req_wdata_i = wd;
    req_priv_i  = priv;
    check("req_ready_before_accept", 64'(req_ready_o), 64'd1);
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    check("resp_valid_after_accept", 64'(resp_valid_o), 64'd1);
    rd = resp_rdata_o;
    er = resp_error_o;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk_i); #1; end
  endtask

  initial begin
    logic [63:0] rd;
    logic        er;

    rst_ni = 1'b0; req_valid_i = 1'b0; req_op_i = OP_READ; req_addr_i = '0;
    req_wdata_i = '0; req_priv_i = PRIV_M; resp_ready_i = 1'b1;

    #12;
    check("reset_resp_valid", 64'(resp_valid_o), 64'd0);
    check("reset_resp_rdata", resp_rdata_o, 64'd0);
    check("reset_resp_error", 64'(resp_error_o), 64'd0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    idle(1);

    add_vec(OP_WRITE, 12'h340, 64'hDEAD,   PRIV_M, 64'h0,    1'b0);
    add_vec(OP_READ,  12'h340, 64'h0,      PRIV_M, 64'hDEAD, 1'b0);
    add_vec(OP_WRITE, 12'h340, 64'hF0,     PRIV_M, 64'hDEAD, 1'b0);
    add_vec(OP_SET,   12'h340, 64'h0F,     PRIV_M, 64'hF0,   1'b0);
    add_vec(OP_CLEAR, 12'h340, 64'hF0,     PRIV_M, 64'hFF,   1'b0);
    add_vec(OP_READ,  12'h340, 64'h0,      PRIV_M, 64'h0F,   1'b0);
    add_vec(OP_READ,  12'h340, 64'h0,      PRIV_U, 64'h0,    1'b1);
    add_vec(OP_WRITE, 12'h340, 64'h1234,   PRIV_U, 64'h0,    1'b1);
    add_vec(OP_READ,  12'h340, 64'h0,      PRIV_S, 64'h0,    1'b1);
    add_vec(OP_READ,  12'h340, 64'h0,      PRIV_M, 64'h0F,   1'b0);
    add_vec(OP_WRITE, 12'h140, 64'h5,      PRIV_S, 64'h0,    1'b0);
    add_vec(OP_READ,  12'h140, 64'h0,      PRIV_S, 64'h5,    1'b0);
    add_vec(OP_READ,  12'h140, 64'h0,      PRIV_U, 64'h0,    1'b1);
    add_vec(OP_CLEAR, 12'h140, 64'h0,      PRIV_S, 64'h5,    1'b0);
    add_vec(OP_READ,  12'h140, 64'h0,      PRIV_M, 64'h5,    1'b0);
    add_vec(OP_WRITE, 12'hC00, 64'h1,      PRIV_U, 64'h0,    1'b1);
    add_vec(OP_READ,  12'hF14, 64'h0,      PRIV_M, 64'h5,    1'b0);
    add_vec(OP_WRITE, 12'hF14, 64'h0,      PRIV_M, 64'h0,    1'b1);
    add_vec(OP_READ,  12'h7FF, 64'h0,      PRIV_M, 64'h0,    1'b1);
    add_vec(OP_READ,  12'h341, 64'h0,      PRIV_M, 64'h0,    1'b1);
    add_vec(OP_WRITE, 12'hB00, 64'h0,      PRIV_S, 64'h0,    1'b1);

    foreach (vecs[i]) begin
      do_req(vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].priv, rd, er);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("vec%0d_error", i), 64'(er), 64'(vecs[i].exp_err));
    end

    // mcycle: write then read k accept edges later returns written + (k-1), wrapping.
    do_req(OP_WRITE, 12'hB00, ALL_ONES, PRIV_M, rd, er);
    check("mcycle_write_err", 64'(er), 64'd0);
    do_req(OP_SET, 12'hC00, 64'h0, PRIV_U, rd, er);
    check("cycle_set0_rdata", rd, ALL_ONES);
    check("cycle_set0_err", 64'(er), 64'd0);
    do_req(OP_WRITE, 12'hB00, ALL_ONES, PRIV_M, rd, er);
    idle(1);
    do_req(OP_READ, 12'hC00, 64'h0, PRIV_U, rd, er);
    check("mcycle_wrap", rd, 64'h0);
    do_req(OP_WRITE, 12'hB00, 64'h100, PRIV_M, rd, er);
    idle(3);
    do_req(OP_READ, 12'hB00, 64'h0, PRIV_M, rd, er);
    check("mcycle_count", rd, 64'h103);

    // Backpressure: stalled response holds, next request waits, then one response per cycle.
    do_req(OP_WRITE, 12'h340, 64'hA5, PRIV_M, rd, er);
    idle(1);
    resp_ready_i = 1'b0;
    do_req(OP_READ, 12'h340, 64'h0, PRIV_M, rd, er);
    check("bp_first_rdata", rd, 64'hA5);
    req_valid_i = 1'b1; req_op_i = OP_SET; req_addr_i = 12'h340;
    req_wdata_i = 64'h100; req_priv_i = PRIV_M;
    for (int i = 0; i < 3; i++) begin
      check("bp_ready_low", 64'(req_ready_o), 64'd0);
      check("bp_valid_held", 64'(resp_valid_o), 64'd1);
      check("bp_rdata_held", resp_rdata_o, 64'hA5);
      @(posedge clk_i); #1;
    end
    resp_ready_i = 1'b1;
    #1;
    check("bp_ready_comb", 64'(req_ready_o), 64'd1);
    @(posedge clk_i); #1;
    check("bp_second_valid", 64'(resp_valid_o), 64'd1);
    check("bp_second_rdata", resp_rdata_o, 64'hA5);
    req_op_i = OP_READ; req_wdata_i = 64'h0;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    check("bp_third_valid", 64'(resp_valid_o), 64'd1);
    check("bp_third_rdata", resp_rdata_o, 64'h1A5);
    @(posedge clk_i); #1;
    check("bp_drain_valid", 64'(resp_valid_o), 64'd0);

    // Reset while a response is pending.
    resp_ready_i = 1'b0;
    do_req(OP_READ, 12'h340, 64'h0, PRIV_M, rd, er);
    rst_ni = 1'b0;
    #1;
    check("midreset_valid", 64'(resp_valid_o), 64'd0);
    check("midreset_rdata", resp_rdata_o, 64'd0);
    #1;
    rst_ni = 1'b1;
    resp_ready_i = 1'b1;
    do_req(OP_READ, 12'h340, 64'h0, PRIV_M, rd, er);
    check("post_reset_mscratch", rd, 64'h0);
    check("post_reset_err", 64'(er), 64'd0);

    idle(1);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
